// File: rtl/router_rd_sink.sv
// router_rd_sink: destination-side reader for one router 1x3 output port.
// Drains one packet per vld_out episode (header, payload, parity), streams the
// payload on rx_data/rx_valid and reports length, address and parity status.
// Optional build macro RD_SINK_STATS_EN adds saturating pkt_cnt/err_cnt outputs.
module router_rd_sink #(
    parameter logic [1:0]  PORT_ID   = 2'd0,
    parameter int unsigned START_DLY = 0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       pkt_done,
    output logic [5:0] pkt_len,
    output logic [1:0] pkt_addr,
    output logic       parity_err,
    output logic       addr_err,
    output logic       len_err
`ifdef RD_SINK_STATS_EN
    ,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READ,
        DONE
    } state_t;

    // Last WAIT count value; unused when START_DLY is zero (WAIT is skipped).
    localparam logic [4:0] DLY_LAST = (START_DLY > 0) ? 5'(START_DLY - 1) : 5'd0;

    state_t     state;
    state_t     state_nxt;
    logic [4:0] dly_cnt;
    logic [6:0] issued;
    logic [6:0] total;
    logic [6:0] cap_cnt;
    logic       rd_q;
    logic [7:0] par;
    logic       cap_hdr;
    logic       cap_pay;
    logic       cap_last;

    // Read strobe and capture classification of the byte currently on data_out.
    always_comb begin
        read_enb = (state == READ) && vld_out && (issued < total);
        cap_hdr  = rd_q && (cap_cnt == 7'd0);
        cap_last = rd_q && (cap_cnt != 7'd0) && (cap_cnt == total - 7'd1);
        cap_pay  = rd_q && (cap_cnt != 7'd0) && !cap_last;
        pkt_done = (state == DONE);
    end

    // Next-state logic; the packet ends on the edge that captures the parity byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (vld_out) state_nxt = (START_DLY > 0) ? WAIT : READ;
            WAIT: if (dly_cnt == DLY_LAST) state_nxt = READ;
            READ: if (cap_last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Read/capture counters, running parity, payload stream and packet status.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            dly_cnt    <= '0;
            issued     <= '0;
            total      <= '0;
            cap_cnt    <= '0;
            rd_q       <= 1'b0;
            par        <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            pkt_len    <= '0;
            pkt_addr   <= '0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            rd_q     <= read_enb;
            rx_valid <= cap_pay;
            if (cap_pay) rx_data <= data_out;

            if (state == WAIT) dly_cnt <= dly_cnt + 5'd1;
            else               dly_cnt <= '0;

            // Outside READ the counters sit at their entry values, so READ
            // always starts with total=3 until the header says otherwise.
            if (state != READ) begin
                issued  <= '0;
                cap_cnt <= '0;
                total   <= 7'd3;
            end else begin
                if (read_enb) issued  <= issued + 7'd1;
                if (rd_q)     cap_cnt <= cap_cnt + 7'd1;
                if (cap_hdr)
                    total <= (data_out[7:2] == 6'd0) ? 7'd2 : {1'b0, data_out[7:2]} + 7'd2;
            end

            if (state == IDLE)          par <= '0;
            else if (cap_hdr || cap_pay) par <= par ^ data_out;

            if (cap_hdr) begin
                pkt_len  <= data_out[7:2];
                pkt_addr <= data_out[1:0];
            end

            if (cap_last) begin
                parity_err <= (par != data_out);
                addr_err   <= (pkt_addr != PORT_ID);
                len_err    <= (pkt_len == 6'd0);
            end
        end
    end

`ifdef RD_SINK_STATS_EN
    // Saturating packet and error counters, stepped on the pkt_done cycle.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else if (pkt_done) begin
            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 16'd1;
            if ((parity_err || addr_err || len_err) && (err_cnt != '1))
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_router_rd_sink.sv
// Bench for router_rd_sink: two instances (lane 0: PORT_ID=1, no start delay;
// lane 1: PORT_ID=0, START_DLY=5), each fed by a simple FIFO model. A packet
// level model predicts payload bytes and per-packet status from the header.
module tb_router_rd_sink;

    localparam logic [1:0]  PID_A = 2'd1;
    localparam logic [1:0]  PID_B = 2'd0;
    localparam int unsigned DLY_A = 0;
    localparam int unsigned DLY_B = 5;

    logic       clock;
    logic       resetn;
    logic       vld   [2];
    logic [7:0] dout  [2] = '{8'h00, 8'h00};
    logic       rd    [2];
    logic [7:0] rxd   [2];
    logic       rxv   [2];
    logic       done  [2];
    logic [5:0] plen  [2];
    logic [1:0] paddr [2];
    logic       perr  [2];
    logic       aerr  [2];
    logic       lerr  [2];
`ifdef RD_SINK_STATS_EN
    logic [15:0] pcnt [2];
    logic [15:0] ecnt [2];
`endif

    // FIFO model state
    logic [7:0] mem [2][64];
    int         wp [2] = '{0, 0};
    int         rp [2] = '{0, 0};
    logic       hold  [2] = '{1'b0, 1'b0};
    logic       flush [2] = '{1'b0, 1'b0};

    // Packet model state
    logic [7:0] exp_byte [2][256];
    int exp_wr [2] = '{0, 0};
    int exp_rd [2] = '{0, 0};
    int sent   [2] = '{0, 0};
    int rec_rd [2] = '{0, 0};
    int e_len [2][16], e_addr [2][16], e_perr [2][16], e_aerr [2][16];
    int e_lerr [2][16], e_reads [2][16], e_nrx [2][16];
    int send_cyc [2];

    // Observed per-packet facts
    int rds [2] = '{0, 0};
    int rxs [2] = '{0, 0};
    int first_rd [2], last_rd [2];
    int d_reads [2], d_rx [2], d_perr [2], d_aerr [2], d_lerr [2], d_first [2], d_last [2];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    router_rd_sink #(.PORT_ID(PID_A), .START_DLY(DLY_A)) u_dut_a (
        .clock(clock), .resetn(resetn), .vld_out(vld[0]), .data_out(dout[0]),
        .read_enb(rd[0]), .rx_data(rxd[0]), .rx_valid(rxv[0]), .pkt_done(done[0]),
        .pkt_len(plen[0]), .pkt_addr(paddr[0]), .parity_err(perr[0]),
        .addr_err(aerr[0]), .len_err(lerr[0])
`ifdef RD_SINK_STATS_EN
        , .pkt_cnt(pcnt[0]), .err_cnt(ecnt[0])
`endif
    );

    router_rd_sink #(.PORT_ID(PID_B), .START_DLY(DLY_B)) u_dut_b (
        .clock(clock), .resetn(resetn), .vld_out(vld[1]), .data_out(dout[1]),
        .read_enb(rd[1]), .rx_data(rxd[1]), .rx_valid(rxv[1]), .pkt_done(done[1]),
        .pkt_len(plen[1]), .pkt_addr(paddr[1]), .parity_err(perr[1]),
        .addr_err(aerr[1]), .len_err(lerr[1])
`ifdef RD_SINK_STATS_EN
        , .pkt_cnt(pcnt[1]), .err_cnt(ecnt[1])
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    assign vld[0] = (rp[0] != wp[0]) && !hold[0];
    assign vld[1] = (rp[1] != wp[1]) && !hold[1];

    // FIFO: one byte out per read strobe, visible the cycle after the strobe.
    always @(posedge clock) begin
        for (int l = 0; l < 2; l++) begin
            if (flush[l]) rp[l] <= wp[l];
            else if (rd[l] && (rp[l] != wp[l])) begin
                dout[l] <= mem[l][rp[l] % 64];
                rp[l]   <= rp[l] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int l, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s lane%0d: got %0d, expected %0d (cycle %0d)", nm, l, act, req, cyc);
        end
    endtask

    function automatic int port_of(input int l);
        return (l == 0) ? int'(PID_A) : int'(PID_B);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Queue a packet (n bytes, first byte in the most significant used byte of v)
    // into a lane's FIFO and predict everything the reader must report for it.
    task automatic send(input int l, input int n, input logic [63:0] v);
        logic [7:0] b [16];
        logic [7:0] x;
        int len;
        int idx;
        for (int i = 0; i < n; i++) begin
            b[i] = v[8*(n-1-i) +: 8];
            mem[l][wp[l] % 64] = b[i];
            wp[l]++;
        end
        len = int'(b[0][7:2]);
        x   = b[0];
        for (int k = 1; k <= len; k++) begin
            x = x ^ b[k];
            exp_byte[l][exp_wr[l] % 256] = b[k];
            exp_wr[l]++;
        end
        idx = sent[l] % 16;
        e_len[l][idx]   = len;
        e_addr[l][idx]  = int'(b[0][1:0]);
        e_perr[l][idx]  = int'(x != b[len+1]);
        e_aerr[l][idx]  = int'(int'(b[0][1:0]) != port_of(l));
        e_lerr[l][idx]  = int'(len == 0);
        e_reads[l][idx] = len + 2;
        e_nrx[l][idx]   = len;
        // cycle index (as counted at negedges) in which vld_out is first high
        send_cyc[l] = cyc + 1;
        sent[l]++;
    endtask

    task automatic wait_done(input int l);
        for (int k = 0; k < 200 && rec_rd[l] != sent[l]; k++) step();
        chk("done_wait", l, int'(rec_rd[l] == sent[l]), 1);
    endtask

    // Compare process: every cycle, checks DUT outputs against the packet model.
    always @(negedge clock) begin
        int idx;
        cyc = cyc + 1;
        for (int l = 0; l < 2; l++) begin
            if (!resetn) begin
                rds[l]    = 0;
                rxs[l]    = 0;
                exp_rd[l] = exp_wr[l];
                rec_rd[l] = sent[l];
            end else begin
                if (rd[l]) begin
                    chk("read_needs_vld", l, int'(vld[l]), 1);
                    if (rds[l] == 0) first_rd[l] = cyc;
                    last_rd[l] = cyc;
                    rds[l]++;
                end
                if (rxv[l]) begin
                    chk("rx_expected", l, int'(exp_rd[l] != exp_wr[l]), 1);
                    if (exp_rd[l] != exp_wr[l]) begin
                        chk("rx_data", l, int'(rxd[l]), int'(exp_byte[l][exp_rd[l] % 256]));
                        exp_rd[l]++;
                    end
                    rxs[l]++;
                end
                if (done[l]) begin
                    chk("done_expected", l, int'(rec_rd[l] != sent[l]), 1);
                    if (rec_rd[l] != sent[l]) begin
                        idx = rec_rd[l] % 16;
                        chk("pkt_len", l, int'(plen[l]), e_len[l][idx]);
                        chk("pkt_addr", l, int'(paddr[l]), e_addr[l][idx]);
                        chk("parity_err", l, int'(perr[l]), e_perr[l][idx]);
                        chk("addr_err", l, int'(aerr[l]), e_aerr[l][idx]);
                        chk("len_err", l, int'(lerr[l]), e_lerr[l][idx]);
                        chk("read_count", l, rds[l], e_reads[l][idx]);
                        chk("rx_count", l, rxs[l], e_nrx[l][idx]);
                        rec_rd[l]++;
                    end
                    d_reads[l] = rds[l];
                    d_rx[l]    = rxs[l];
                    d_perr[l]  = int'(perr[l]);
                    d_aerr[l]  = int'(aerr[l]);
                    d_lerr[l]  = int'(lerr[l]);
                    d_first[l] = first_rd[l];
                    d_last[l]  = last_rd[l];
                    rds[l] = 0;
                    rxs[l] = 0;
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        repeat (3) step();
        for (int l = 0; l < 2; l++) begin
            chk("rst_read_enb", l, int'(rd[l]), 0);
            chk("rst_rx_valid", l, int'(rxv[l]), 0);
            chk("rst_pkt_done", l, int'(done[l]), 0);
            chk("rst_pkt_len", l, int'(plen[l]), 0);
            chk("rst_pkt_addr", l, int'(paddr[l]), 0);
            chk("rst_errs", l, int'({perr[l], aerr[l], lerr[l]}), 0);
        end
        resetn = 1'b1;
        step();

        // Good packet, len 4 addr 1 on PORT_ID=1
        send(0, 6, 64'h11_01_02_03_04_15);
        wait_done(0);
        chk("lit_first_read_gap", 0, d_first[0] - send_cyc[0], 1);
        chk("lit_reads", 0, d_reads[0], 6);
        chk("lit_read_span", 0, d_last[0] - d_first[0] + 1, 6);
        chk("lit_rx_pulses", 0, d_rx[0], 4);
        chk("lit_pkt_len", 0, int'(plen[0]), 4);
        chk("lit_pkt_addr", 0, int'(paddr[0]), 1);
        chk("lit_errs", 0, d_perr[0] + d_aerr[0] + d_lerr[0], 0);
        repeat (2) step();

        // Same packet with a wrong parity byte
        send(0, 6, 64'h11_01_02_03_04_14);
        wait_done(0);
        chk("lit_parity_err", 0, d_perr[0], 1);
        chk("lit_addr_ok", 0, d_aerr[0], 0);
        repeat (2) step();

        // Zero-length header: two reads only, no payload
        send(0, 2, 64'h00_00);
        wait_done(0);
        chk("lit_zero_reads", 0, d_reads[0], 2);
        chk("lit_zero_len_err", 0, d_lerr[0], 1);
        chk("lit_zero_rx", 0, d_rx[0], 0);
        repeat (2) step();

        // Delayed start with a 3-cycle vld_out stall after the third read
        send(1, 6, 64'h10_AA_BB_CC_DD_10);
        for (int k = 0; k < 100 && rds[1] < 3; k++) step();
        chk("stall_wait", 1, int'(rds[1] >= 3), 1);
        hold[1] = 1'b1;
        repeat (3) step();
        hold[1] = 1'b0;
        wait_done(1);
        chk("lit_start_dly_gap", 1, d_first[1] - send_cyc[1], 6);
        chk("lit_stall_span", 1, d_last[1] - d_first[1] + 1, 9);
        chk("lit_stall_reads", 1, d_reads[1], 6);
        chk("lit_stall_errs", 1, d_perr[1] + d_aerr[1] + d_lerr[1], 0);
        repeat (2) step();

        // Reset during the payload; leftover bytes flushed while the reader idles
        send(0, 6, 64'h11_01_02_03_04_15);
        for (int k = 0; k < 100 && rxs[0] < 1; k++) step();
        chk("reset_wait", 0, int'(rxs[0] >= 1), 1);
        resetn = 1'b0;
        step();
        chk("lit_rst_vld_still_high", 0, int'(vld[0]), 1);
        chk("lit_rst_read_enb", 0, int'(rd[0]), 0);
        chk("lit_rst_pkt_len", 0, int'(plen[0]), 0);
`ifdef RD_SINK_STATS_EN
        chk("lit_rst_pkt_cnt", 0, int'(pcnt[0]), 0);
`endif
        hold[0]  = 1'b1;
        flush[0] = 1'b1;
        resetn   = 1'b1;
        step();
        hold[0]  = 1'b0;
        flush[0] = 1'b0;
        repeat (10) step();

        // Recovery after reset
        send(0, 6, 64'h11_01_02_03_04_15);
        wait_done(0);
        chk("lit_recover_reads", 0, d_reads[0], 6);
        chk("lit_recover_errs", 0, d_perr[0] + d_aerr[0] + d_lerr[0], 0);
        repeat (2) step();

        // Address mismatch on PORT_ID=0: payload still streamed
        send(1, 6, 64'h11_01_02_03_04_15);
        wait_done(1);
        chk("lit_addr_err", 1, d_aerr[1], 1);
        chk("lit_addr_rx_pulses", 1, d_rx[1], 4);
        chk("lit_addr_parity_ok", 1, d_perr[1], 0);
        repeat (3) step();

`ifdef RD_SINK_STATS_EN
        chk("lit_pkt_cnt", 0, int'(pcnt[0]), 1);
        chk("lit_err_cnt", 0, int'(ecnt[0]), 0);
        chk("lit_pkt_cnt", 1, int'(pcnt[1]), 1);
        chk("lit_err_cnt", 1, int'(ecnt[1]), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
